// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline encodings: main-opcode classes, ALU ops, forwarding
// codes and branch conditions. Decode and execute both import this package.
package rv32_pkg;

  localparam logic [1:0] CLS_ALU_REG = 2'b00;
  localparam logic [1:0] CLS_ALU_IMM = 2'b01;
  localparam logic [2:0] CLS_LOAD    = 3'b100;
  localparam logic [2:0] CLS_STORE   = 3'b101;
  localparam logic [2:0] CLS_BRANCH  = 3'b110;

  localparam logic [5:0] OPC_LUI    = 6'b111000;
  localparam logic [5:0] OPC_AUIPC  = 6'b111001;
  localparam logic [5:0] OPC_JAL    = 6'b111010;
  localparam logic [5:0] OPC_JALR   = 6'b111011;
  localparam logic [5:0] OPC_BUBBLE = 6'b111111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  localparam logic [3:0] FWD_RS1_ONE     = 4'b0000;
  localparam logic [3:0] FWD_RS2_ONE     = 4'b0001;
  localparam logic [3:0] FWD_RS1_TWO     = 4'b0010;
  localparam logic [3:0] FWD_RS2_TWO     = 4'b0011;
  localparam logic [3:0] FWD_RS1_MEM     = 4'b0100;
  localparam logic [3:0] FWD_RS2_MEM     = 4'b0101;
  localparam logic [3:0] FWD_RS1ONE_RS2TWO = 4'b0110;
  localparam logic [3:0] FWD_RS2ONE_RS1TWO = 4'b0111;
  localparam logic [3:0] FWD_BOTH_ONE    = 4'b1000;
  localparam logic [3:0] FWD_BOTH_TWO    = 4'b1001;
  localparam logic [3:0] FWD_NONE        = 4'b1111;

  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  typedef enum logic [1:0] {
    SRC_RF,
    SRC_ONE,
    SRC_TWO,
    SRC_MEM
  } fwd_src_e;

endpackage

// File: rtl/rv32_alu.sv
// Combinational RV32I integer ALU; undefined ops produce zero.
module rv32_alu
  import rv32_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_op,
  output logic [XLEN-1:0] result
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;
  logic [4:0]             shamt;

  assign a_s   = $signed(a);
  assign b_s   = $signed(b);
  assign shamt = b[4:0];

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned(a_s >>> shamt);
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/pipeline_ex.sv
// RV32I execute stage: operand forwarding, ALU/address/branch/jump evaluation,
// wrong-path squashing after a redirect, and registered outputs to memory/fetch.
module pipeline_ex
  import rv32_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int SQUASH_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic [4:0]      rs1_i,
  input  logic [4:0]      rs2_i,
  input  logic [4:0]      rd_i,
  input  logic [3:0]      alu_op_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [5:0]      main_opcode_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [3:0]      reg_forwarding_type_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [XLEN-1:0] mem_data_i,
  output logic [XLEN-1:0] result_o,
  output logic [XLEN-1:0] store_data_o,
  output logic [4:0]      rd_o,
  output logic [5:0]      main_opcode_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] target_o
);

  localparam int CNT_W = (SQUASH_DEPTH < 1) ? 1 : $clog2(SQUASH_DEPTH + 1);

  logic [XLEN-1:0]  result_q, result_d;
  logic [XLEN-1:0]  store_data_q, store_data_d;
  logic [XLEN-1:0]  target_q, target_d;
  logic [XLEN-1:0]  two_q;
  logic [4:0]       rd_q, rd_d;
  logic [5:0]       opc_q, opc_d;
  logic             redirect_q, redirect_d;
  logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

  fwd_src_e               sel_a, sel_b;
  logic [XLEN-1:0]        op_a, op_b, alu_b, alu_res;
  logic signed [XLEN-1:0] op_a_s, op_b_s;
  logic                   is_alu, is_mem, is_br, is_lui, is_auipc, is_jal, is_jalr;
  logic                   is_valid, squash, br_taken;

  // Register indices are resolved by decode into the forwarding code.
  logic unused_idx;
  assign unused_idx = ^{rs1_i, rs2_i};

  always_comb begin
    sel_a = SRC_RF;
    sel_b = SRC_RF;
    case (reg_forwarding_type_i)
      FWD_RS1_ONE:       sel_a = SRC_ONE;
      FWD_RS2_ONE:       sel_b = SRC_ONE;
      FWD_RS1_TWO:       sel_a = SRC_TWO;
      FWD_RS2_TWO:       sel_b = SRC_TWO;
      FWD_RS1_MEM:       sel_a = SRC_MEM;
      FWD_RS2_MEM:       sel_b = SRC_MEM;
      FWD_RS1ONE_RS2TWO: begin sel_a = SRC_ONE; sel_b = SRC_TWO; end
      FWD_RS2ONE_RS1TWO: begin sel_a = SRC_TWO; sel_b = SRC_ONE; end
      FWD_BOTH_ONE:      begin sel_a = SRC_ONE; sel_b = SRC_ONE; end
      FWD_BOTH_TWO:      begin sel_a = SRC_TWO; sel_b = SRC_TWO; end
      default:           ;
    endcase

    case (sel_a)
      SRC_ONE: op_a = result_q;
      SRC_TWO: op_a = two_q;
      SRC_MEM: op_a = mem_data_i;
      default: op_a = rs1_data_i;
    endcase
    case (sel_b)
      SRC_ONE: op_b = result_q;
      SRC_TWO: op_b = two_q;
      SRC_MEM: op_b = mem_data_i;
      default: op_b = rs2_data_i;
    endcase
  end

  assign op_a_s   = $signed(op_a);
  assign op_b_s   = $signed(op_b);
  assign is_alu   = (main_opcode_i[5:4] == CLS_ALU_REG) || (main_opcode_i[5:4] == CLS_ALU_IMM);
  assign is_mem   = (main_opcode_i[5:3] == CLS_LOAD) || (main_opcode_i[5:3] == CLS_STORE);
  assign is_br    = (main_opcode_i[5:3] == CLS_BRANCH);
  assign is_lui   = (main_opcode_i == OPC_LUI);
  assign is_auipc = (main_opcode_i == OPC_AUIPC);
  assign is_jal   = (main_opcode_i == OPC_JAL);
  assign is_jalr  = (main_opcode_i == OPC_JALR);
  assign is_valid = is_alu | is_mem | is_br | is_lui | is_auipc | is_jal | is_jalr;
  assign squash   = (squash_cnt_q != '0);
  assign alu_b    = (main_opcode_i[5:4] == CLS_ALU_REG) ? op_b : imm_i;

  rv32_alu #(.XLEN(XLEN)) u_alu (
    .a      (op_a),
    .b      (alu_b),
    .alu_op (alu_op_i),
    .result (alu_res)
  );

  always_comb begin
    case (main_opcode_i[2:0])
      BR_EQ:   br_taken = (op_a == op_b);
      BR_NE:   br_taken = (op_a != op_b);
      BR_LT:   br_taken = (op_a_s < op_b_s);
      BR_GE:   br_taken = (op_a_s >= op_b_s);
      BR_LTU:  br_taken = (op_a < op_b);
      BR_GEU:  br_taken = (op_a >= op_b);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    result_d     = '0;
    store_data_d = '0;
    target_d     = '0;
    rd_d         = '0;
    opc_d        = OPC_BUBBLE;
    redirect_d   = 1'b0;
    squash_cnt_d = squash ? (squash_cnt_q - CNT_W'(1)) : squash_cnt_q;

    // Squashed slots and unrecognised 111xxx codes both leave as bubbles.
    if (!squash && is_valid) begin
      rd_d         = rd_i;
      opc_d        = main_opcode_i;
      store_data_d = op_b;
      if (is_alu) begin
        result_d = alu_res;
      end else if (is_mem) begin
        result_d = op_a + imm_i;
      end else if (is_lui) begin
        result_d = imm_i;
      end else if (is_auipc) begin
        result_d = pc_i + imm_i;
      end else if (is_jal || is_jalr) begin
        result_d   = pc_i + XLEN'(4);
        redirect_d = 1'b1;
        target_d   = is_jal ? (pc_i + imm_i) : ((op_a + imm_i) & ~XLEN'(1));
      end else if (is_br && br_taken) begin
        redirect_d = 1'b1;
        target_d   = pc_i + imm_i;
      end
      if (redirect_d) squash_cnt_d = CNT_W'(SQUASH_DEPTH);
    end
  end

  // Execute -> memory stage boundary; two_q trails result_q by one cycle.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      result_q     <= '0;
      store_data_q <= '0;
      target_q     <= '0;
      two_q        <= '0;
      rd_q         <= '0;
      opc_q        <= OPC_BUBBLE;
      redirect_q   <= 1'b0;
      squash_cnt_q <= '0;
    end else begin
      result_q     <= result_d;
      store_data_q <= store_data_d;
      target_q     <= target_d;
      two_q        <= result_q;
      rd_q         <= rd_d;
      opc_q        <= opc_d;
      redirect_q   <= redirect_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign result_o      = result_q;
  assign store_data_o  = store_data_q;
  assign target_o      = target_q;
  assign rd_o          = rd_q;
  assign main_opcode_o = opc_q;
  assign redirect_o    = redirect_q;

endmodule

// File: tb/tb_pipeline_ex.sv
// Directed-vector bench for the RV32I execute stage.
module tb_pipeline_ex;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic [4:0]  rs1, rs2, rd;
  logic [3:0]  alu_op, fwd;
  logic [31:0] imm, pc, rs1_data, rs2_data, mem_data;
  logic [5:0]  opc;
  logic [31:0] result, store_data, target;
  logic [4:0]  rd_out;
  logic [5:0]  opc_out;
  logic        redirect;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipeline_ex #(.XLEN(32), .SQUASH_DEPTH(2)) dut (
    .clk_i                 (clk),
    .reset_ni              (reset_ni),
    .rs1_i                 (rs1),
    .rs2_i                 (rs2),
    .rd_i                  (rd),
    .alu_op_i              (alu_op),
    .imm_i                 (imm),
    .main_opcode_i         (opc),
    .pc_i                  (pc),
    .reg_forwarding_type_i (fwd),
    .rs1_data_i            (rs1_data),
    .rs2_data_i            (rs2_data),
    .mem_data_i            (mem_data),
    .result_o              (result),
    .store_data_o          (store_data),
    .rd_o                  (rd_out),
    .main_opcode_o         (opc_out),
    .redirect_o            (redirect),
    .target_o              (target)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] o, input logic [3:0] op, input logic [3:0] f,
                       input logic [4:0] d, input logic [31:0] p, input logic [31:0] im,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] m);
    opc = o; alu_op = op; fwd = f; rd = d; pc = p; imm = im;
    rs1_data = a; rs2_data = b; mem_data = m;
    rs1 = 5'd1; rs2 = 5'd2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_ni = 1'b0;
    drive(6'b111111, 4'h0, 4'hF, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    check("rst_result", result, 32'h0);
    check("rst_store", store_data, 32'h0);
    check("rst_target", target, 32'h0);
    check("rst_rd", {27'd0, rd_out}, 32'd0);
    check("rst_opc", {26'd0, opc_out}, 32'h3F);
    check("rst_redirect", {31'd0, redirect}, 32'd0);

    reset_ni = 1'b1;
    // ADD 5+7, then ADD with rs1 from ONE (12) plus 1, then both from TWO (12+12).
    drive(6'b000000, 4'b0000, 4'hF, 5'd3, 32'h0, 32'h0, 32'd5, 32'd7, 32'h0);
    tick();
    check("add", result, 32'd12);
    check("add_rd", {27'd0, rd_out}, 32'd3);
    check("add_opc", {26'd0, opc_out}, 32'h00);
    drive(6'b000000, 4'b0000, 4'b0000, 5'd4, 32'h0, 32'h0, 32'd100, 32'd1, 32'h0);
    tick();
    check("add_fwd_one", result, 32'd13);
    drive(6'b000000, 4'b0000, 4'b1001, 5'd4, 32'h0, 32'h0, 32'd100, 32'd200, 32'h0);
    tick();
    check("add_fwd_two", result, 32'd24);

    drive(6'b000000, 4'b1000, 4'hF, 5'd4, 32'h0, 32'h0, 32'd3, 32'd5, 32'h0);
    tick();
    check("sub", result, 32'hFFFF_FFFE);
    drive(6'b010000, 4'b1101, 4'hF, 5'd4, 32'h0, 32'd4, 32'h8000_0000, 32'd0, 32'h0);
    tick();
    check("srai", result, 32'hF800_0000);
    drive(6'b000000, 4'b1001, 4'hF, 5'd4, 32'h0, 32'h0, 32'd3, 32'd5, 32'h0);
    tick();
    check("undef_aluop", result, 32'h0);
    drive(6'b111001, 4'b0000, 4'hF, 5'd8, 32'h1000, 32'h2000, 32'h0, 32'h0, 32'h0);
    tick();
    check("auipc", result, 32'h3000);

    // Store with rs2 forwarded from the load data bus.
    drive(6'b101010, 4'b0000, 4'b0101, 5'd0, 32'h0, 32'd4, 32'h100, 32'h55, 32'hDEAD);
    tick();
    check("ls_addr", result, 32'h104);
    check("ls_store_data", store_data, 32'hDEAD);
    check("ls_opc", {26'd0, opc_out}, 32'h2A);

    // Taken BEQ, then two squashed slots, then normal execution.
    drive(6'b110000, 4'b0000, 4'hF, 5'd0, 32'h40, 32'h20, 32'd9, 32'd9, 32'h0);
    tick();
    check("beq_redirect", {31'd0, redirect}, 32'd1);
    check("beq_target", target, 32'h60);
    check("beq_result", result, 32'h0);
    drive(6'b000000, 4'b0000, 4'hF, 5'd5, 32'h44, 32'h0, 32'd1, 32'd2, 32'h0);
    tick();
    check("sq1_opc", {26'd0, opc_out}, 32'h3F);
    check("sq1_rd", {27'd0, rd_out}, 32'd0);
    check("sq1_result", result, 32'h0);
    check("sq1_redirect", {31'd0, redirect}, 32'd0);
    drive(6'b111010, 4'b0000, 4'hF, 5'd1, 32'h80, 32'h10, 32'd0, 32'd0, 32'h0);
    tick();
    check("sq2_opc", {26'd0, opc_out}, 32'h3F);
    check("sq2_redirect", {31'd0, redirect}, 32'd0);
    drive(6'b000000, 4'b0000, 4'hF, 5'd6, 32'h60, 32'h0, 32'd1, 32'd2, 32'h0);
    tick();
    check("post_sq_result", result, 32'd3);
    check("post_sq_rd", {27'd0, rd_out}, 32'd6);

    // BNE on equal and BLTU -1<1 are not taken; BLT -1<1 is taken.
    drive(6'b110001, 4'b0000, 4'hF, 5'd0, 32'h70, 32'h20, 32'd9, 32'd9, 32'h0);
    tick();
    check("bne_not_taken", {31'd0, redirect}, 32'd0);
    drive(6'b110110, 4'b0000, 4'hF, 5'd0, 32'h70, 32'h20, 32'hFFFF_FFFF, 32'd1, 32'h0);
    tick();
    check("bltu_not_taken", {31'd0, redirect}, 32'd0);
    drive(6'b110100, 4'b0000, 4'hF, 5'd0, 32'h70, 32'h20, 32'hFFFF_FFFF, 32'd1, 32'h0);
    tick();
    check("blt_taken", {31'd0, redirect}, 32'd1);
    check("blt_target", target, 32'h90);
    drive(6'b111111, 4'b0000, 4'hF, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    tick();
    check("redirect_one_cycle", {31'd0, redirect}, 32'd0);
    tick();

    // JALR then reset while the squash counter is loaded.
    drive(6'b111011, 4'b0000, 4'hF, 5'd1, 32'h10, 32'd2, 32'h203, 32'h0, 32'h0);
    tick();
    check("jalr_result", result, 32'h14);
    check("jalr_target", target, 32'h204);
    check("jalr_redirect", {31'd0, redirect}, 32'd1);
    reset_ni = 1'b0;
    drive(6'b000000, 4'b0000, 4'hF, 5'd9, 32'h0, 32'h0, 32'd1, 32'd1, 32'h0);
    tick();
    check("mid_rst_result", result, 32'h0);
    check("mid_rst_target", target, 32'h0);
    check("mid_rst_opc", {26'd0, opc_out}, 32'h3F);
    check("mid_rst_redirect", {31'd0, redirect}, 32'd0);
    reset_ni = 1'b1;
    drive(6'b000000, 4'b0000, 4'hF, 5'd7, 32'h0, 32'h0, 32'd4, 32'd5, 32'h0);
    tick();
    check("post_rst_result", result, 32'd9);
    check("post_rst_rd", {27'd0, rd_out}, 32'd7);
    check("post_rst_opc", {26'd0, opc_out}, 32'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ex.md
# pipeline_ex

Execute stage of the RV32I five-stage pipeline. It consumes the registered decode bundle from the decode stage: register indices, ALU op, immediate, main opcode, PC and forwarding type. It also takes register-file read data and the memory-stage load data. It resolves forwarding, computes ALU, address, branch and jump results, and squashes wrong-path instructions after a taken control transfer. All outputs are registered and feed the memory stage and the fetch redirect.

## Interface
Parameters:
- `XLEN`, 32: datapath width; only 32 is supported.
- `SQUASH_DEPTH`, 2: number of younger instructions squashed after a redirect.

Ports (all active-high unless noted):
- `clk_i` input, 1: clock.
- `reset_ni` input, 1: reset, synchronous, active-low.
- `rs1_i`, `rs2_i`, `rd_i` input, 5 each: register indices from decode.
- `alu_op_i` input, 4: ALU op from decode.
- `imm_i` input, 32: sign-extended immediate.
- `main_opcode_i` input, 6: instruction class code.
- `pc_i` input, 32: PC of the instruction.
- `reg_forwarding_type_i` input, 4: forwarding selector.
- `rs1_data_i`, `rs2_data_i` input, 32 each: register-file read data.
- `mem_data_i` input, 32: load data returned by the memory stage in the current cycle.
- `result_o` output, 32: ALU result, effective address, link value or upper immediate.
- `store_data_o` output, 32: forwarded rs2 value.
- `rd_o` output, 5: destination register.
- `main_opcode_o` output, 6: opcode passed to the memory stage; 6'b111111 marks a bubble.
- `redirect_o` output, 1: taken branch or jump.
- `target_o` output, 32: redirect PC.

## Operation
- **Opcode classes:**
  - 00_xxxx: ALU register, operand B = rs2.
  - 01_xxxx: ALU immediate, operand B = imm.
  - 100fff: load.
  - 101fff: store.
  - 110fff: branch.
  - 111000: LUI.
  - 111001: AUIPC.
  - 111010: JAL.
  - 111011: JALR.
  - Any other 111xxx: bubble.
- **ALU ops:** 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
  - Shift amount = B[4:0].
  - All arithmetic is modulo 2^32.
- **Forwarding sources:**
  - ONE = `result_o` of the previous cycle.
  - TWO = the result from two cycles ago, held in an internal history register.
  - MEM = `mem_data_i`.
- **Forwarding codes (otherwise the operand comes from register-file data):**
  - 0000: rs1←ONE.
  - 0001: rs2←ONE.
  - 0010: rs1←TWO.
  - 0011: rs2←TWO.
  - 0100: rs1←MEM.
  - 0101: rs2←MEM.
  - 0110: rs1←ONE, rs2←TWO.
  - 0111: rs2←ONE, rs1←TWO.
  - 1000: both←ONE.
  - 1001: both←TWO.
  - 1111 and all undefined codes: no forwarding.
- **Results:**
  - Load/store: result = rs1+imm; `store_data_o` = forwarded rs2.
  - LUI: result = imm.
  - AUIPC: result = pc+imm.
  - JAL: result = pc+4, target = pc+imm.
  - JALR: result = pc+4, target = (rs1+imm) & ~1.
  - Branch: result = 0. Funct3 = opcode[2:0]: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU. If taken, target = pc+imm.
- **Redirect:** `redirect_o` is asserted for a taken branch, JAL or JALR that is not squashed.
- **Squash counter (0..SQUASH_DEPTH):**
  - Loads SQUASH_DEPTH when a redirect is produced.
  - While nonzero, the incoming instruction is converted to a bubble: `main_opcode_o` = 111111, `rd_o` = 0, `redirect_o` = 0, `result_o` = 0. The counter then decrements.
  - A control instruction arriving while squashing never redirects and never reloads the counter.
- **History:** ONE and TWO update every cycle, bubbles included; a bubble carries result 0.

## Timing
- One-cycle latency: inputs sampled at edge N appear on the outputs after edge N.
- Forwarding muxes are combinational from the current inputs and the history registers.
- `redirect_o` and `target_o` are valid for exactly one cycle per taken transfer.
- Reset (`reset_ni` = 0 at an edge) sets:
  - `result_o`, `store_data_o`, `target_o`, `rd_o` = 0.
  - `main_opcode_o` = 111111.
  - `redirect_o` = 0.
  - History registers = 0 and the squash counter = 0.
- Reset mid-squash clears the squash counter, so the first instruction after reset executes normally.
- An undefined `alu_op_i` value yields result 0.

## Structure
- Shared package `rv32_pkg` holds: main-opcode constants, ALU-op constants, forwarding-code constants, branch funct3 constants and the BUBBLE opcode. The decode stage adopts the same package.
- One sub-module, `rv32_alu`: combinational; inputs a, b, alu_op; output result.
- Forwarding muxes, branch compare, target adders, squash counter and output registers live in `pipeline_ex`.

## Test plan
- **ADD with ALU_ONE forwarding.** Cycle 1: ADD, rs1_data=5, rs2_data=7, rd=3. Cycle 2: ADD with code 0000, rs2_data=1. Required: result_o 12, then 13.
- **SUB/SRA.** SUB with 3−5 → 0xFFFFFFFE. SRA (alu_op 1101) of 0x80000000 by 4 → 0xF8000000.
- **Load-use.** code 0101, mem_data_i=0xDEAD, store opcode 101010, rs1_data=0x100, imm=4. Required: result_o 0x104, store_data_o 0xDEAD.
- **Taken BEQ and squash.** BEQ at pc 0x40, rs1 = rs2 = 9, imm=0x20. Required: redirect_o=1, target_o=0x60. The next two inputs (ADD rd=5, JAL) emerge as bubbles with no redirect; the third executes normally.
- **JALR.** pc=0x10, rs1=0x203, imm=2. Required: result_o 0x14, target_o 0x204, redirect_o 1.
- **Reset mid-squash.** Assert `reset_ni`=0 one cycle after a redirect. Required: all outputs take their reset values; the next ADD after release executes unsquashed.
